// File: rtl/skew_feed_buffer_pkg.sv
// rtl/skew_feed_buffer_pkg.sv - shared sizing defaults and controller state type for the skew feed buffer
package Config;

    localparam int sys_rows           = 4;
    localparam int A_BITWIDTH         = 8;
    localparam int input_buffer_depth = 16;

    localparam int CFG_ROWS   = sys_rows;
    localparam int CFG_DWIDTH = A_BITWIDTH;
    localparam int CFG_DEPTH  = input_buffer_depth;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } feed_state_t;

endpackage

// File: rtl/skew_feed_buffer_fifo.sv
// rtl/skew_feed_buffer_fifo.sv - single-clock row FIFO with registered read data
module sync_fifo #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 16,
    parameter int LEN_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_en,
    output logic [DWIDTH-1:0] dout,
    output logic [LEN_W-1:0]  count,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LEN_W-1:0]  r_count;
    logic [DWIDTH-1:0] r_dout;
    logic              w_push;
    logic              w_pop;

    // full is taken from the registered count, so a pop never frees room for a same-cycle push
    assign full   = (r_count == LEN_W'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_push = wr_en & ~full;
    assign w_pop  = rd_en & ~empty;
    assign count  = r_count;
    assign dout   = r_dout;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_dout   <= r_mem[r_rd_ptr];
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + LEN_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - LEN_W'(1);
            end
        end
    end

endmodule

// File: rtl/skew_feed_buffer.sv
// rtl/skew_feed_buffer.sv - per-row FIFOs feeding a skewed operand wavefront into the array west edge
module skew_feed_buffer
    import Config::*;
#(
    parameter int ROWS   = CFG_ROWS,
    parameter int DWIDTH = CFG_DWIDTH,
    parameter int DEPTH  = CFG_DEPTH,
    parameter int LEN_W  = $clog2(DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ROWS-1:0]              wr_en,
    input  logic [ROWS-1:0][DWIDTH-1:0]  wr_data,
    output logic [ROWS-1:0]              full,
    input  logic                         start,
    input  logic [LEN_W-1:0]             tile_len,
    input  logic                         stall,
    output logic                         start_err,
    output logic                         busy,
    output logic                         done,
    output logic [ROWS-1:0]              o_valid,
    output logic [ROWS-1:0][DWIDTH-1:0]  o_data
);
    localparam int                 DRAIN_W    = $clog2(ROWS) + 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(ROWS - 1);

    feed_state_t        r_state;
    feed_state_t        w_state_nxt;
    logic [LEN_W-1:0]   r_issue_cnt;
    logic [LEN_W-1:0]   w_issue_cnt_nxt;
    logic [DRAIN_W-1:0] r_drain_cnt;
    logic [DRAIN_W-1:0] w_drain_cnt_nxt;
    logic [ROWS-2:0]    r_skew;
    logic [ROWS-1:0]    w_issue;
    logic [ROWS-1:0]    w_rd_en;
    logic [ROWS-1:0]    w_empty;
    logic [LEN_W-1:0]   w_count [ROWS];
    logic [ROWS-1:0]    r_valid;
    logic               r_done;
    logic               r_start_err;
    logic               r_busy_tail;
    logic               w_enough;
    logic               w_zero_start;
    logic               w_reject;
    logic               w_drain_end;

    // row 0 issues straight from the controller; row i sees the same pattern i non-stalled cycles later
    assign w_issue   = {r_skew, (r_state == RUN)};
    assign w_rd_en   = w_issue & ~{ROWS{stall}} & ~w_empty;
    assign o_valid   = r_valid;
    assign done      = r_done;
    assign start_err = r_start_err;
    assign busy      = (r_state != IDLE) | r_busy_tail;

    for (genvar g = 0; g < ROWS; g++) begin : g_row
        sync_fifo #(
            .DWIDTH (DWIDTH),
            .DEPTH  (DEPTH),
            .LEN_W  (LEN_W)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_en[g]),
            .wr_data (wr_data[g]),
            .rd_en   (w_rd_en[g]),
            .dout    (o_data[g]),
            .count   (w_count[g]),
            .full    (full[g]),
            .empty   (w_empty[g])
        );
    end

    always_comb begin
        w_enough = 1'b1;
        for (int i = 0; i < ROWS; i++) begin
            if (w_count[i] < tile_len) begin
                w_enough = 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_issue_cnt_nxt = r_issue_cnt;
        w_drain_cnt_nxt = r_drain_cnt;
        w_zero_start    = 1'b0;
        w_reject        = 1'b0;
        w_drain_end     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (tile_len == '0) begin
                        w_zero_start = 1'b1;
                    end else if (!w_enough) begin
                        w_reject = 1'b1;
                    end else begin
                        w_state_nxt     = RUN;
                        w_issue_cnt_nxt = tile_len;
                    end
                end
            end
            RUN: begin
                if (!stall) begin
                    w_issue_cnt_nxt = r_issue_cnt - LEN_W'(1);
                    if (r_issue_cnt == LEN_W'(1)) begin
                        w_state_nxt     = DRAIN;
                        w_drain_cnt_nxt = '0;
                    end
                end
            end
            DRAIN: begin
                if (!stall) begin
                    if (r_drain_cnt == DRAIN_LAST) begin
                        w_state_nxt = IDLE;
                        w_drain_end = 1'b1;
                    end else begin
                        w_drain_cnt_nxt = r_drain_cnt + DRAIN_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_issue_cnt <= '0;
            r_drain_cnt <= '0;
            r_skew      <= '0;
            r_valid     <= '0;
            r_done      <= 1'b0;
            r_start_err <= 1'b0;
            r_busy_tail <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_issue_cnt <= w_issue_cnt_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            if (!stall) begin
                r_skew <= w_issue[ROWS-2:0];
            end
            r_valid     <= w_rd_en;
            r_done      <= w_zero_start | w_drain_end;
            r_start_err <= w_reject;
            r_busy_tail <= w_drain_end;
        end
    end

endmodule
